// File: rtl/period_avg_pkg.sv
// rtl/period_avg_pkg.sv - shared state type, default sizes and accumulator width helper for period_avg_filter
package period_avg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_LOG2_N = 3;
  localparam int DEF_DROP_W = 8;

  // Sum of 2^log2_n words of width bits can never exceed width+log2_n bits.
  function automatic int acc_width(input int width, input int log2_n);
    return width + log2_n;
  endfunction

endpackage

// File: rtl/period_minmax_track.sv
// rtl/period_minmax_track.sv - running min/max register pair for one averaging window
module period_minmax_track
  import period_avg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_first,
  input  logic             update,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] max
);

  always_ff @(posedge clk) begin
    if (rst) begin
      min <= '0;
      max <= '0;
    end else if (load_first) begin
      min <= data;
      max <= data;
    end else if (update) begin
      if (data < min) min <= data;
      if (data > max) max <= data;
    end
  end

endmodule

// File: rtl/period_avg_filter.sv
// rtl/period_avg_filter.sv - windowed mean of meter counts with drop counter and no-signal flag
// Define PERIOD_AVG_MINMAX_EN to add the min_data/max_data window outputs.
module period_avg_filter
  import period_avg_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LOG2_N = DEF_LOG2_N,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              meas_valid,
  input  logic [WIDTH-1:0]  meas_data,
  input  logic              sw_clear,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [WIDTH-1:0]  avg_data,
`ifdef PERIOD_AVG_MINMAX_EN
  output logic [WIDTH-1:0]  min_data,
  output logic [WIDTH-1:0]  max_data,
`endif
  output logic [DROP_W-1:0] drop_cnt,
  output logic              no_signal
);

  localparam int ACC_W = acc_width(WIDTH, LOG2_N);
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] N_CNT     = CNT_W'(2 ** LOG2_N);
  localparam logic [CNT_W-1:0] ZRUN_LAST = N_CNT - CNT_W'(1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] zero_run;
  logic             clr, nz, zs, hs;
  logic             accept, first, drop, done;

  assign clr = rst | sw_clear;
  assign nz  = meas_valid && (meas_data != '0);
  assign zs  = meas_valid && (meas_data == '0);
  assign hs  = avg_valid && avg_ready;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    first     = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        accept = nz;
        first  = nz;
      end
      ACCUM: accept = nz;
      HOLD: begin
        // A sample arriving with the handshake opens the next window instead of being lost.
        if (hs) begin
          state_nxt = IDLE;
          accept    = nz;
          first     = nz;
        end else begin
          drop = nz;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cnt_nxt = first ? CNT_W'(1) : cnt + CNT_W'(1);
    acc_nxt = first ? ACC_W'(meas_data) : acc + ACC_W'(meas_data);
    done    = accept && (cnt_nxt == N_CNT);
    if (accept) state_nxt = done ? HOLD : ACCUM;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc       <= '0;
      cnt       <= '0;
      zero_run  <= '0;
      avg_valid <= 1'b0;
      avg_data  <= '0;
      drop_cnt  <= '0;
    end else begin
      if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end
      if (done) begin
        avg_valid <= 1'b1;
        avg_data  <= acc_nxt[LOG2_N +: WIDTH];
      end else if (hs) begin
        avg_valid <= 1'b0;
      end
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
      if (nz)                               zero_run <= '0;
      else if (zs && (zero_run != N_CNT))   zero_run <= zero_run + CNT_W'(1);
    end
  end

  // Soft clear leaves the loss-of-signal indication untouched.
  always_ff @(posedge clk) begin
    if (rst)                                      no_signal <= 1'b0;
    else if (!sw_clear && nz)                     no_signal <= 1'b0;
    else if (!sw_clear && zs && zero_run >= ZRUN_LAST) no_signal <= 1'b1;
  end

`ifdef PERIOD_AVG_MINMAX_EN
  logic [WIDTH-1:0] trk_min, trk_max, win_min, win_max;

  period_minmax_track #(.WIDTH(WIDTH)) u_minmax (
    .clk        (clk),
    .rst        (clr),
    .load_first (accept && first),
    .update     (accept && !first),
    .data       (meas_data),
    .min        (trk_min),
    .max        (trk_max)
  );

  // Fold the completing sample in so the published extrema cover the whole window.
  always_comb begin
    win_min = first ? meas_data : ((meas_data < trk_min) ? meas_data : trk_min);
    win_max = first ? meas_data : ((meas_data > trk_max) ? meas_data : trk_max);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      min_data <= '0;
      max_data <= '0;
    end else if (done) begin
      min_data <= win_min;
      max_data <= win_max;
    end
  end
`endif

endmodule

// File: tb/tb_period_avg_filter.sv
// tb/tb_period_avg_filter.sv - scoreboard bench for period_avg_filter against a window-list reference model
module tb_period_avg_filter;

  localparam int N = 8;

  typedef struct {
    logic [15:0] avg;
    logic [15:0] mn;
    logic [15:0] mx;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, sw_clear, meas_valid, avg_ready;
  logic [15:0] meas_data;
  logic        avg_valid, no_signal;
  logic [15:0] avg_data;
  logic [7:0]  drop_cnt;
`ifdef PERIOD_AVG_MINMAX_EN
  logic [15:0] min_data, max_data;
`endif

  int checks   = 0;
  int failures = 0;

  res_t        exp_q[$];
  int          m_win[$];
  logic        m_held;
  int          m_drops;
  int          m_zrun;
  logic        m_nosig;

  always #5 clk = ~clk;

  period_avg_filter #(.WIDTH(16), .LOG2_N(3), .DROP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .meas_valid (meas_valid),
    .meas_data  (meas_data),
    .sw_clear   (sw_clear),
    .avg_valid  (avg_valid),
    .avg_ready  (avg_ready),
    .avg_data   (avg_data),
`ifdef PERIOD_AVG_MINMAX_EN
    .min_data   (min_data),
    .max_data   (max_data),
`endif
    .drop_cnt   (drop_cnt),
    .no_signal  (no_signal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: a window is a list of non-zero samples; the result is their integer mean.
  task automatic model_step();
    logic nz, zs, hs;
    nz = meas_valid && (meas_data != 16'd0);
    zs = meas_valid && (meas_data == 16'd0);
    if (rst || sw_clear) begin
      if (m_held && !avg_ready) void'(exp_q.pop_back());
      m_win.delete();
      m_held  = 1'b0;
      m_drops = 0;
      m_zrun  = 0;
      if (rst) m_nosig = 1'b0;
      return;
    end
    hs = m_held && avg_ready;
    if (nz) begin
      m_zrun  = 0;
      m_nosig = 1'b0;
      if (m_held && !hs) begin
        if (m_drops < 255) m_drops++;
      end else begin
        m_win.push_back(int'(meas_data));
      end
    end
    if (hs) m_held = 1'b0;
    if (m_win.size() == N) begin
      res_t r;
      int   sum, mn, mx;
      sum = 0; mn = 32'h7fffffff; mx = 0;
      foreach (m_win[i]) begin
        sum += m_win[i];
        if (m_win[i] < mn) mn = m_win[i];
        if (m_win[i] > mx) mx = m_win[i];
      end
      r.avg = 16'(sum / N);
      r.mn  = 16'(mn);
      r.mx  = 16'(mx);
      exp_q.push_back(r);
      m_win.delete();
      m_held = 1'b1;
    end
    if (zs) begin
      if (m_zrun < N) m_zrun++;
      if (m_zrun == N) m_nosig = 1'b1;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic mv, input logic [15:0] md, input logic rdy);
    @(posedge clk);
    #1;
    chk("avg_valid", {31'd0, avg_valid}, {31'd0, m_held});
    chk("drop_cnt", {24'd0, drop_cnt}, m_drops);
    chk("no_signal", {31'd0, no_signal}, {31'd0, m_nosig});
    rst = r; sw_clear = s; meas_valid = mv; meas_data = md; avg_ready = rdy;
    model_step();
  endtask

  always @(negedge clk) begin
    if (avg_valid === 1'b1 && avg_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none", avg_data);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("avg_data", {16'd0, avg_data}, {16'd0, e.avg});
`ifdef PERIOD_AVG_MINMAX_EN
        chk("min_data", {16'd0, min_data}, {16'd0, e.mn});
        chk("max_data", {16'd0, max_data}, {16'd0, e.mx});
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; sw_clear = 1'b0; meas_valid = 1'b0; meas_data = 16'd0; avg_ready = 1'b0;
    m_held = 1'b0; m_drops = 0; m_zrun = 0; m_nosig = 1'b0;
    model_step();
    cyc(1, 0, 0, 16'd0, 0);
    cyc(0, 0, 0, 16'd0, 0);
    chk("reset_avg_data", {16'd0, avg_data}, 32'd0);

    // Ramp 100..107 with consumer always ready
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'(100 + i), 1);
    cyc(0, 0, 0, 16'd0, 1);
    cyc(0, 0, 0, 16'd0, 1);

    // Held result with three dropped samples
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'd300, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 16'd500, 0);
    cyc(0, 0, 0, 16'd0, 0);
    chk("t2_drop_cnt", {24'd0, drop_cnt}, 32'd3);
    chk("t2_avg_held", {16'd0, avg_data}, 32'd300);
    cyc(0, 0, 0, 16'd0, 1);
    cyc(0, 0, 0, 16'd0, 1);

    // Full-scale samples must not wrap
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'hFFFF, 1);
    cyc(0, 0, 0, 16'd0, 1);
    cyc(0, 0, 0, 16'd0, 1);

    // Loss of signal then recovery
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'd0, 1);
    cyc(0, 0, 0, 16'd0, 1);
    chk("t4_no_signal", {31'd0, no_signal}, 32'd1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'd50, 1);
    cyc(0, 0, 0, 16'd0, 1);
    cyc(0, 0, 0, 16'd0, 1);

    // Reset mid-window discards the partial sum
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 16'd900, 1);
    cyc(1, 0, 0, 16'd0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'd200, 1);
    cyc(0, 0, 0, 16'd0, 1);
    cyc(0, 0, 0, 16'd0, 1);

    // Handshake coinciding with the first sample of the next window
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'd7, 0);
    cyc(0, 0, 0, 16'd0, 0);
    cyc(0, 0, 1, 16'd10, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 16'd10, 1);
    cyc(0, 0, 0, 16'd0, 1);
    cyc(0, 0, 0, 16'd0, 1);

    // Drop counter saturation
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'd1, 0);
    for (int i = 0; i < 260; i++) cyc(0, 0, 1, 16'd9, 0);
    cyc(0, 0, 0, 16'd0, 0);
    chk("drop_saturate", {24'd0, drop_cnt}, 32'd255);
    cyc(0, 0, 0, 16'd0, 1);

    // Soft clear keeps no_signal but clears the drop counter
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 16'd0, 1);
    cyc(0, 1, 1, 16'd33, 1);
    cyc(0, 0, 0, 16'd0, 1);
    chk("sw_clear_keeps_no_signal", {31'd0, no_signal}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, mv, rdy;
      logic [15:0] d;
      int          k;
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 199) == 0);
      mv  = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 2) != 0);
      k   = $urandom_range(0, 9);
      if (k < 2)      d = 16'd0;
      else if (k < 6) d = 16'($urandom_range(1, 50));
      else if (k < 9) d = 16'($urandom);
      else            d = 16'hFFFF;
      cyc(r, s, mv, d, rdy);
    end

    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 16'd0, 1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/period_avg_filter.md
Name: period_avg_filter

Overview:
- Downstream consumer of the frequency/period meter's latched count.
- Accepts one measurement per latch event and averages a window of 2^LOG2_N non-zero samples.
- Presents the mean, plus optional window min/max, to the readout side over a valid/ready handshake.
- Flags loss of test signal, i.e. a run of zero counts.

Parameters:
- WIDTH, 16: width of measurement and result words.
- LOG2_N, 3: log2 of window length; N = 2^LOG2_N samples per result.
- DROP_W, 8: width of the saturating dropped-sample counter.

Ports:
- clk  in  1  single design clock; the meter's reference clock domain.
- rst  in  1  synchronous reset, active-high.
- meas_valid  in  1  one-cycle strobe; meas_data is a new measurement.
- meas_data  in  WIDTH  latched edge count from the meter.
- sw_clear  in  1  synchronous soft clear.
- avg_valid  out  1  result available.
- avg_ready  in  1  consumer accepts result.
- avg_data  out  WIDTH  window mean.
- min_data  out  WIDTH  window minimum; exists only with the macro.
- max_data  out  WIDTH  window maximum; exists only with the macro.
- drop_cnt  out  DROP_W  samples lost while a result was held; saturating.
- no_signal  out  1  N consecutive zero measurements seen.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0 and state IDLE. Accumulator, sample count and zero-run count are cleared. A reset mid-window discards the partial sum.
- Priority: rst > sw_clear > normal operation.
- sw_clear: same effect as rst, except no_signal is preserved.
- Accumulator: ACC_W = WIDTH+LOG2_N bits, unsigned, so it cannot overflow.
- Result: avg_data = acc >> LOG2_N, truncating.
- State IDLE:
  - meas_valid with non-zero data: acc = data, cnt = 1, go to ACCUM.
  - Zero data: ignored.
- State ACCUM:
  - Each non-zero meas_valid adds data to acc and increments cnt.
  - On the Nth sample: go to HOLD; avg_valid = 1 on the next clk edge (latency 1 cycle from the last accepted sample).
- State HOLD:
  - avg_data, min_data and max_data are stable while avg_valid = 1.
  - Each non-zero meas_valid is dropped and increments drop_cnt, saturating at 2^DROP_W-1.
  - When avg_valid && avg_ready: avg_valid drops next cycle and the block goes to IDLE.
  - Non-zero meas_valid in the same cycle as the handshake: accepted as sample 1 of the next window (go to ACCUM, cnt = 1), not dropped.
- Zero samples (meas_valid with data == 0):
  - Never accumulated and never dropped.
  - Increment zero_run, saturating at N.
  - no_signal = 1 once zero_run == N.
  - The first non-zero sample clears zero_run and no_signal in the same cycle it is accepted.
  - Zero samples do not break an in-progress window.
- meas_valid with rst or sw_clear asserted: the sample is ignored.
- avg_ready with avg_valid = 0: no effect.

Optional Feature:
PERIOD_AVG_MINMAX_EN:
- Defined: min_data and max_data ports exist and track the min/max of the window's accepted samples.
  - The first sample of a window loads both.
  - Both are updated alongside avg_data and held through HOLD.
  - Reset value 0.
- Undefined: ports absent, no tracking logic, all other behaviour identical.

Decomposition:
- Package period_avg_pkg holds:
  - state typedef (IDLE, ACCUM, HOLD);
  - default WIDTH / LOG2_N / DROP_W constants;
  - helper function computing ACC_W.
- One sub-module, period_minmax_track: compare-and-hold register pair.
  - Instantiated only under PERIOD_AVG_MINMAX_EN.
  - Ports: clk, rst, load_first, update, data, min, max.

Test Plan:
All cases use WIDTH=16, LOG2_N=3.
1. Eight strobes, data 100..107, avg_ready=1 → avg_valid high exactly 1 cycle after the 8th strobe; avg_data=103; min_data=100, max_data=107 (macro defined).
2. Complete a window with avg_ready=0, then three further strobes of 500 → drop_cnt=3; avg_data unchanged; after avg_ready=1 the block returns to IDLE.
3. Eight strobes of 0xFFFF → avg_data=0xFFFF, no wrap.
4. Eight zero strobes → no_signal=1 and no avg_valid. Then a strobe of 50 → no_signal=0 and it counts as sample 1; seven more 50s → avg_data=50.
5. Five strobes of 900, then rst for 1 cycle, then eight strobes of 200 → avg_data=200; drop_cnt=0.
6. Result held; handshake in the same cycle as a strobe of 10, then seven strobes of 10 → second avg_data=10, drop_cnt unchanged.
